// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared width, op and FSM encodings, and divide special-case results.
package muldiv_pkg;
    localparam int XLEN = 32;
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
    localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
    localparam logic [XLEN-1:0] OVF_Q = {1'b1, {(XLEN-1){1'b0}}};
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: restores two's-complement signs on magnitude results and selects the op's output word.
module muldiv_sign_fix
    import muldiv_pkg::*;
(
    input  op_e             op_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic            neg_res_i,
    input  logic            neg_rem_i,
    output logic [XLEN-1:0] res_o
);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo, rem;
    assign prod = neg_res_i ? -{hi_i, lo_i} : {hi_i, lo_i};
    assign quo = neg_res_i ? -lo_i : lo_i;
    assign rem = neg_rem_i ? -hi_i : hi_i;
    always_comb res_o = op_i[2] ? (op_i[1] ? rem : quo) : (op_i == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide, one bit per CALC cycle.
// The divider is built only with MULDIV_DIV_EN defined; otherwise div ops complete at once with 0.
module mul_div_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            mul_en,
    input  logic            div_en,
    input  logic [2:0]      funct3,
    input  logic            flush,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_e state_q, state_d;
    op_e op_q, op_d;
    logic [4:0] cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, res_q, res_d, fix_res, a_mag, b_mag;
    logic neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, a_neg, b_neg;
    logic [XLEN:0] mul_sum;

    assign a_neg = op_a[XLEN-1] & (mul_en ? funct3[1:0] != 2'b11 : !funct3[0]);
    assign b_neg = op_b[XLEN-1] & (mul_en ? !funct3[1] : !funct3[0]);
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
`ifdef MULDIV_DIV_EN
    logic [XLEN:0] div_sh, div_diff;
    logic div_take, div_ovf;
    assign div_sh = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, m_q};
    // A carried-out shifted remainder always exceeds the 32-bit divisor.
    assign div_take = div_sh[XLEN] | !div_diff[XLEN];
    assign div_ovf = !funct3[0] && op_a == OVF_Q && op_b == '1;
`endif

    always_comb begin
        state_d = state_q;
        op_d = op_q;
        cnt_d = cnt_q;
        hi_d = hi_q;
        lo_d = lo_q;
        m_d = m_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        res_d = res_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mul_en) begin
                        op_d = op_e'({1'b0, funct3[1:0]});
                        {hi_d, lo_d, m_d} = {{XLEN{1'b0}}, b_mag, a_mag};
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = 1'b0;
                        cnt_d = 5'd31;
                        state_d = S_CALC;
                    end else if (div_en) begin
                        op_d = op_e'({1'b1, funct3[1:0]});
                        state_d = S_DONE;
`ifdef MULDIV_DIV_EN
                        if (op_b == '0) begin
                            res_d = funct3[1] ? op_a : DIV_ZERO_Q;
                        end else if (div_ovf) begin
                            res_d = funct3[1] ? '0 : OVF_Q;
                        end else begin
                            {hi_d, lo_d, m_d} = {{XLEN{1'b0}}, a_mag, b_mag};
                            neg_res_d = a_neg ^ b_neg;
                            neg_rem_d = a_neg;
                            cnt_d = 5'd31;
                            state_d = S_CALC;
                        end
`else
                        res_d = '0;
`endif
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q - 5'd1;
                    state_d = cnt_q == '0 ? S_FIX : S_CALC;
                    {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
                    if (op_q[2]) {hi_d, lo_d} = {div_take ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0], lo_q[XLEN-2:0], div_take};
`endif
                end
                S_FIX: begin
                    res_d = fix_res;
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q <= OP_MUL;
            {cnt_q, hi_q, lo_q, m_q, res_q, neg_res_q, neg_rem_q} <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            {cnt_q, hi_q, lo_q, m_q, res_q, neg_res_q, neg_rem_q} <= {cnt_d, hi_d, lo_d, m_d, res_d, neg_res_d, neg_rem_d};
        end
    end

    muldiv_sign_fix u_sign_fix (
        .op_i      (op_q),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .neg_res_i (neg_res_q),
        .neg_rem_i (neg_rem_q),
        .res_o     (fix_res)
    );

    assign busy = state_q != S_IDLE;
    assign done = state_q == S_DONE;
    assign result = res_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench; driver queues expected result and completion cycle, monitor checks on done.
module tb_mul_div_unit;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic clk, rst, mul_en, div_en, flush, busy, done;
    logic [2:0] funct3;
    logic [31:0] op_a, op_b, result;
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_res = '0;
    exp_t sb_q[$];
    exp_t mon_e;

    mul_div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .mul_en (mul_en),
        .div_en (div_en),
        .funct3 (funct3),
        .flush  (flush),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Reference: full-width signed/unsigned arithmetic straight from the ISA definition.
    function automatic void model(input logic me, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output int lat);
        logic [63:0] as64, au64, bs64, bu64, p;
        int sa, sb;
        as64 = {{32{a[31]}}, a};
        au64 = {32'b0, a};
        bs64 = {{32{b[31]}}, b};
        bu64 = {32'b0, b};
        sa = a;
        sb = b;
        lat = 34;
        r = '0;
        if (me) begin
            case (f[1:0])
                2'b00: begin p = as64 * bs64; r = p[31:0]; end
                2'b01: begin p = as64 * bs64; r = p[63:32]; end
                2'b10: begin p = as64 * bu64; r = p[63:32]; end
                default: begin p = au64 * bu64; r = p[63:32]; end
            endcase
        end else if (!DIV_EN) begin
            lat = 1;
        end else if (b == 0) begin
            lat = 1;
            r = f[1] ? a : 32'hFFFF_FFFF;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lat = 1;
            r = f[1] ? 32'h0 : 32'h8000_0000;
        end else begin
            case (f[1:0])
                2'b00: r = sa / sb;
                2'b01: r = a / b;
                2'b10: r = sa % sb;
                default: r = a % b;
            endcase
        end
    endfunction

    // Called at a negedge in IDLE; issues one op, checks busy through its whole life.
    task automatic run_op(input logic me, input logic de, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b, input bit poke);
        exp_t e;
        int lat;
        model(me, f, a, b, e.res, lat);
        e.cyc = cyc + lat;
        sb_q.push_back(e);
        mul_en = me;
        div_en = de;
        funct3 = f;
        op_a = a;
        op_b = b;
        @(negedge clk);
        mul_en = 1'b0;
        div_en = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            chk("busy_run", {31'b0, busy}, 32'd1);
            mul_en = poke && k == 5;
            op_a = $urandom;
            op_b = $urandom;
            @(negedge clk);
            mul_en = 1'b0;
        end
        chk("busy_idle", {31'b0, busy}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done at cycle %0d: got done with result %h, want no completion", cyc, result);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", result, mon_e.res);
                chk("done_cycle", cyc, mon_e.cyc);
                last_res = mon_e.res;
            end
        end else begin
            chk("result_hold", result, last_res);
        end
    end

    initial begin
        logic me, de;
        rst = 1'b1;
        {mul_en, div_en, flush} = '0;
        funct3 = '0;
        op_a = '0;
        op_b = '0;
        @(negedge clk);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 0, 3'b000, 32'd7, -32'sd3, 0);
        run_op(1, 0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(1, 0, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(1, 0, 3'b010, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0);
        run_op(1, 0, 3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        run_op(0, 1, 3'b100, -32'sd7, 32'd2, 0);
        run_op(0, 1, 3'b110, -32'sd7, 32'd2, 0);
        run_op(0, 1, 3'b101, 32'd100, 32'd7, 0);
        run_op(0, 1, 3'b100, 32'd5, 32'd0, 0);
        run_op(0, 1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(0, 1, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(0, 1, 3'b011, 32'd9, 32'd0, 0);
        run_op(0, 1, 3'b010, -32'sd100, 32'd7, 0);
        run_op(1, 1, 3'b100, 32'd6, 32'd7, 0);
        run_op(1, 0, 3'b000, 32'd1000, 32'd3, 1);
        // Flush in cycle 10 of a MUL, then a fresh op in cycle 11.
        mul_en = 1'b1;
        funct3 = 3'b000;
        op_a = 32'd1234;
        op_b = 32'd5678;
        @(negedge clk);
        mul_en = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {31'b0, busy}, 32'd0);
        chk("flush_hold", result, last_res);
        run_op(1, 0, 3'b011, 32'hDEAD_BEEF, 32'h0000_0100, 0);
        // Flush alongside a strobe blocks the accept.
        mul_en = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        mul_en = 1'b0;
        flush = 1'b0;
        chk("flush_blocks_accept", {31'b0, busy}, 32'd0);
        // Asynchronous reset in cycle 20 of a long op.
        mul_en = !DIV_EN;
        div_en = DIV_EN;
        funct3 = 3'b100;
        op_a = 32'd1000;
        op_b = 32'd7;
        @(negedge clk);
        mul_en = 1'b0;
        div_en = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        last_res = '0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 1, 3'b101, 32'd100, 32'd7, 0);
        for (int i = 0; i < 40; i++) begin
            me = 1'($urandom % 2);
            de = me ? 1'($urandom % 2) : 1'b1;
            run_op(me, de, 3'($urandom), pick(), pick(), 0);
        end
        repeat (3) @(negedge clk);
        chk("sb_drain", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
